fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core.
- Owns the PC and drives the instruction-memory address.
- Captures the fetched word, with its PC and PC+4, for the decode stage; the decode-stage controller reads op/funct from that word.
- Consumes the controller's s_npc and inst_type back from ID to redirect, flush and stall, and detects misaligned redirect targets.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on a bubble or flush.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- imem_addr  out  32  fetch address (always equals pc)
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- stall  in  1  load-use hold from the hazard unit
- id_s_npc  in  2  controller next-PC select for the instruction in ID: 0 N_nPC, 1 J_nPC, 2 JR_nPC, 3 BEQ_nPC
- id_inst_type  in  2  controller type for the instruction in ID: 0 NORMAL, 1 LW, 2 J_TYPE, 3 BEQ
- id_jr_target  in  32  forwarded rs value for JR
- id_beq_target  in  32  ALU result (ID nPC + (sext(imm)<<2)) for a taken BEQ
- if_id_inst  out  32  instruction to ID
- if_id_pc  out  32  PC of if_id_inst
- if_id_npc  out  32  if_id_pc + 4
- if_id_valid  out  1  1 = real instruction, 0 = bubble
- fault  out  1  sticky misaligned-target flag
- redirect_cnt  out  16  count of taken redirects, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (rst=1 at an edge, regardless of state):
  - pc=RESET_PC, if_id_inst=NOP_WORD, if_id_pc=0, if_id_npc=0, if_id_valid=0, fault=0, redirect_cnt=0, state=S_BOOT.
- FSM states: S_BOOT, S_RUN, S_FAULT.
- S_BOOT: lasts one cycle; no capture, IF/ID stays a bubble, pc unchanged; then -> S_RUN. Absorbs imem settling after reset.
- S_RUN, priority order per edge:
  1. stall=1: pc, IF/ID and redirect_cnt hold. A redirect is deferred; ID is also held, so it re-presents it.
  2. redirect: if_id_valid=1, id_s_npc!=0 and id_inst_type is J_TYPE or BEQ (any other combination is treated as N_nPC).
     - Target is {if_id_npc[31:28], if_id_inst[25:0], 2'b00} for J_nPC, id_jr_target for JR_nPC, id_beq_target for BEQ_nPC.
     - If target[1:0]==0: pc=target; IF/ID becomes a bubble (inst=NOP_WORD, valid=0, pc/npc=0); redirect_cnt+1. No delay slot: the word fetched this cycle is discarded.
     - If target[1:0]!=0: fault=1, IF/ID becomes a bubble, pc holds, -> S_FAULT.
  3. Otherwise: IF/ID captures {imem_rdata, pc, pc+4} with valid=1; pc=pc+4. pc+4 wraps modulo 2^32.
- S_FAULT: pc, IF/ID (bubble), fault=1 and redirect_cnt all frozen; stall is ignored; only rst exits.
- Redirect latency: the target is on imem_addr the cycle after the redirect edge, and its instruction is in IF/ID two edges after the redirect.
- stall asserted with if_id_valid=0 holds the bubble; no capture.
- imem_addr is pc directly, with no extra register.

Test Plan:
- Reset then run, imem returns addr-dependent words -> cycle 1 after reset: bubble. Then if_id_pc = 0x3000, 0x3004, 0x3008 on consecutive edges, each with valid=1 and npc=pc+4.
- J: ID holds J index 0x0000C10 at pc 0x3004, id_s_npc=1, type=J_TYPE -> next pc=0x00003040. IF/ID is a bubble for one cycle. redirect_cnt=1.
- Taken BEQ with stall=1 for 2 cycles, id_beq_target=0x3020 -> pc and IF/ID frozen 2 cycles. Redirect to 0x3020 on the first edge with stall=0. redirect_cnt increments once.
- JR with id_jr_target=0x3022 -> fault=1, pc stays at current value, IF/ID stays a bubble indefinitely. Asserting rst restores pc=0x3000 and fault=0.
- id_s_npc=2 with type=NORMAL and valid=1 -> treated as sequential: pc+4, no flush, counter unchanged.
- Preload redirect_cnt to 0xFFFF via 65535 redirects, then one more -> redirect_cnt=0.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: bundles the fetch-stage bus signals.
//   imem_addr/imem_rdata        : instruction-memory address and returned word
//   stall                       : load-use hold from the hazard unit
//   id_s_npc/id_inst_type       : controller next-PC select and type for the word in ID
//   id_jr_target/id_beq_target  : redirect targets computed in ID
//   if_id_inst/pc/npc/valid     : IF/ID pipeline register contents
//   fault                       : sticky misaligned-target flag
//   redirect_cnt                : number of taken redirects (wraps)
// Modport master is the fetch stage; modport slave is the surrounding core/bench.
interface fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic [1:0]  id_s_npc;
    logic [1:0]  id_inst_type;
    logic [31:0] id_jr_target;
    logic [31:0] id_beq_target;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_npc;
    logic        if_id_valid;
    logic        fault;
    logic [15:0] redirect_cnt;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  stall,
        input  id_s_npc,
        input  id_inst_type,
        input  id_jr_target,
        input  id_beq_target,
        output if_id_inst,
        output if_id_pc,
        output if_id_npc,
        output if_id_valid,
        output fault,
        output redirect_cnt
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output stall,
        output id_s_npc,
        output id_inst_type,
        output id_jr_target,
        output id_beq_target,
        input  if_id_inst,
        input  if_id_pc,
        input  if_id_npc,
        input  if_id_valid,
        input  fault,
        input  redirect_cnt
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch and IF/ID pipeline register of the MIPS core.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_if.master: imem address/data, hazard stall, ID-stage redirect
//          controls/targets, IF/ID register outputs, fault flag, redirect counter
// The PC drives imem_addr directly; the returned word is captured into IF/ID
// together with its PC and PC+4. Taken J/JR/BEQ redirects flush the word fetched
// in the same cycle (no delay slot). A misaligned redirect target freezes the
// stage in S_FAULT until reset.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input logic    clk,
    input logic    rst,
    fetch_if.master bus
);
    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    localparam logic [1:0] NPC_N   = 2'd0;
    localparam logic [1:0] NPC_J   = 2'd1;
    localparam logic [1:0] NPC_JR  = 2'd2;
    localparam logic [1:0] NPC_BEQ = 2'd3;

    localparam logic [1:0] TYPE_J   = 2'd2;
    localparam logic [1:0] TYPE_BEQ = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] id_pc_reg, id_pc_next;
    logic [31:0] id_npc_reg, id_npc_next;
    logic        valid_reg, valid_next;
    logic        fault_reg, fault_next;
    logic [15:0] cnt_reg, cnt_next;

    logic [31:0] target;
    logic        redirect_take;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_reg + 32'd4;

    // Only J_TYPE/BEQ instructions may redirect; any other select is sequential.
    assign redirect_take = valid_reg && (bus.id_s_npc != NPC_N) &&
                           ((bus.id_inst_type == TYPE_J) || (bus.id_inst_type == TYPE_BEQ));

    always_comb begin
        target = pc_plus4;
        case (bus.id_s_npc)
            NPC_J:   target = {id_npc_reg[31:28], inst_reg[25:0], 2'b00};
            NPC_JR:  target = bus.id_jr_target;
            NPC_BEQ: target = bus.id_beq_target;
            default: target = pc_plus4;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        inst_next   = inst_reg;
        id_pc_next  = id_pc_reg;
        id_npc_next = id_npc_reg;
        valid_next  = valid_reg;
        fault_next  = fault_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            S_BOOT: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                if (bus.stall) begin
                    // Hold everything; ID is held too and re-presents any redirect.
                end else if (redirect_take) begin
                    inst_next   = NOP_WORD;
                    id_pc_next  = 32'd0;
                    id_npc_next = 32'd0;
                    valid_next  = 1'b0;
                    if (target[1:0] == 2'b00) begin
                        pc_next  = target;
                        cnt_next = cnt_reg + 16'd1;
                    end else begin
                        fault_next = 1'b1;
                        state_next = S_FAULT;
                    end
                end else begin
                    inst_next   = bus.imem_rdata;
                    id_pc_next  = pc_reg;
                    id_npc_next = pc_plus4;
                    valid_next  = 1'b1;
                    pc_next     = pc_plus4;
                end
            end
            default: begin
                // S_FAULT (and any unused encoding) stays frozen until reset.
                state_next = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_BOOT;
            pc_reg     <= RESET_PC;
            inst_reg   <= NOP_WORD;
            id_pc_reg  <= 32'd0;
            id_npc_reg <= 32'd0;
            valid_reg  <= 1'b0;
            fault_reg  <= 1'b0;
            cnt_reg    <= 16'd0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            inst_reg   <= inst_next;
            id_pc_reg  <= id_pc_next;
            id_npc_reg <= id_npc_next;
            valid_reg  <= valid_next;
            fault_reg  <= fault_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign bus.imem_addr    = pc_reg;
    assign bus.if_id_inst   = inst_reg;
    assign bus.if_id_pc     = id_pc_reg;
    assign bus.if_id_npc    = id_npc_reg;
    assign bus.if_id_valid  = valid_reg;
    assign bus.fault        = fault_reg;
    assign bus.redirect_cnt = cnt_reg;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// Instruction memory is modelled combinationally: address 0x3004 holds a J
// with index 0x0000C10, every other address returns the bitwise inverse of
// the address, so captured words identify the fetch address.
module tb_fetch_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fetch_if bus();

    fetch_stage #(
        .RESET_PC(32'h0000_3000),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0000_3004) return 32'h0800_0C10;
        return ~addr;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        bus.id_s_npc      = 2'd0;
        bus.id_inst_type  = 2'd0;
        bus.id_jr_target  = 32'd0;
        bus.id_beq_target = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stall = 1'b0;
        clear_id();
        step();
        step();
        n_checks++;
        if (bus.imem_addr !== 32'h3000 || bus.if_id_valid !== 1'b0 || bus.if_id_inst !== 32'h0 ||
            bus.if_id_pc !== 32'h0 || bus.if_id_npc !== 32'h0 || bus.fault !== 1'b0 ||
            bus.redirect_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h valid=%b inst=%h ifpc=%h npc=%h fault=%b cnt=%h, required pc=3000 others 0",
                     bus.imem_addr, bus.if_id_valid, bus.if_id_inst, bus.if_id_pc, bus.if_id_npc,
                     bus.fault, bus.redirect_cnt);
        end
        $display("reset: pc=%h valid=%b", bus.imem_addr, bus.if_id_valid);
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        rst = 1'b0;
        step();
        n_checks++;
        if (bus.if_id_valid !== 1'b0 || bus.imem_addr !== 32'h3000) begin
            n_fail++;
            $display("FAIL boot_bubble: valid=%b pc=%h, required valid=0 pc=3000", bus.if_id_valid, bus.imem_addr);
        end
        $display("boot: valid=%b pc=%h", bus.if_id_valid, bus.imem_addr);
        for (int i = 0; i < 2; i++) begin
            exp_pc = 32'h3000 + 32'(i * 4);
            step();
            n_checks++;
            if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== exp_pc || bus.if_id_npc !== exp_pc + 32'd4 ||
                bus.if_id_inst !== mem_word(exp_pc) || bus.imem_addr !== exp_pc + 32'd4) begin
                n_fail++;
                $display("FAIL seq_capture: valid=%b ifpc=%h npc=%h inst=%h pc=%h, required 1 %h %h %h %h",
                         bus.if_id_valid, bus.if_id_pc, bus.if_id_npc, bus.if_id_inst, bus.imem_addr,
                         exp_pc, exp_pc + 32'd4, mem_word(exp_pc), exp_pc + 32'd4);
            end
            $display("seq: ifpc=%h inst=%h pc=%h", bus.if_id_pc, bus.if_id_inst, bus.imem_addr);
        end
    endtask

    task automatic test_jump();
        // ID holds the J at 0x3004; pc is 0x3008.
        bus.id_s_npc     = 2'd1;
        bus.id_inst_type = 2'd2;
        step();
        clear_id();
        n_checks++;
        if (bus.imem_addr !== 32'h3040 || bus.if_id_valid !== 1'b0 || bus.if_id_inst !== 32'h0 ||
            bus.if_id_pc !== 32'h0 || bus.redirect_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL jump_redirect: pc=%h valid=%b inst=%h ifpc=%h cnt=%h, required 3040 0 0 0 1",
                     bus.imem_addr, bus.if_id_valid, bus.if_id_inst, bus.if_id_pc, bus.redirect_cnt);
        end
        $display("jump: pc=%h valid=%b cnt=%h", bus.imem_addr, bus.if_id_valid, bus.redirect_cnt);
        step();
        n_checks++;
        if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 32'h3040 || bus.if_id_inst !== mem_word(32'h3040) ||
            bus.imem_addr !== 32'h3044) begin
            n_fail++;
            $display("FAIL jump_target_capture: valid=%b ifpc=%h inst=%h pc=%h, required 1 3040 %h 3044",
                     bus.if_id_valid, bus.if_id_pc, bus.if_id_inst, bus.imem_addr, mem_word(32'h3040));
        end
        $display("jump target: ifpc=%h pc=%h", bus.if_id_pc, bus.imem_addr);
    endtask

    task automatic test_beq_stall();
        bus.id_s_npc      = 2'd3;
        bus.id_inst_type  = 2'd3;
        bus.id_beq_target = 32'h3020;
        bus.stall         = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (bus.imem_addr !== 32'h3044 || bus.if_id_pc !== 32'h3040 || bus.if_id_valid !== 1'b1 ||
                bus.redirect_cnt !== 16'd1) begin
                n_fail++;
                $display("FAIL beq_stall_hold: pc=%h ifpc=%h valid=%b cnt=%h, required 3044 3040 1 1",
                         bus.imem_addr, bus.if_id_pc, bus.if_id_valid, bus.redirect_cnt);
            end
            $display("beq stall %0d: pc=%h ifpc=%h", i, bus.imem_addr, bus.if_id_pc);
        end
        bus.stall = 1'b0;
        step();
        clear_id();
        n_checks++;
        if (bus.imem_addr !== 32'h3020 || bus.if_id_valid !== 1'b0 || bus.redirect_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL beq_redirect: pc=%h valid=%b cnt=%h, required 3020 0 2",
                     bus.imem_addr, bus.if_id_valid, bus.redirect_cnt);
        end
        $display("beq: pc=%h cnt=%h", bus.imem_addr, bus.redirect_cnt);
        // Stall over a bubble keeps the bubble and the pc.
        bus.stall = 1'b1;
        step();
        n_checks++;
        if (bus.if_id_valid !== 1'b0 || bus.imem_addr !== 32'h3020) begin
            n_fail++;
            $display("FAIL stall_bubble: valid=%b pc=%h, required 0 3020", bus.if_id_valid, bus.imem_addr);
        end
        $display("stall bubble: valid=%b pc=%h", bus.if_id_valid, bus.imem_addr);
        bus.stall = 1'b0;
        step();
        n_checks++;
        if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 32'h3020 || bus.imem_addr !== 32'h3024) begin
            n_fail++;
            $display("FAIL beq_target_capture: valid=%b ifpc=%h pc=%h, required 1 3020 3024",
                     bus.if_id_valid, bus.if_id_pc, bus.imem_addr);
        end
        $display("beq target: ifpc=%h pc=%h", bus.if_id_pc, bus.imem_addr);
    endtask

    task automatic test_normal_select();
        bus.id_s_npc     = 2'd2;
        bus.id_inst_type = 2'd0;
        bus.id_jr_target = 32'h0000_5000;
        step();
        clear_id();
        n_checks++;
        if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 32'h3024 || bus.imem_addr !== 32'h3028 ||
            bus.redirect_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL normal_select_seq: valid=%b ifpc=%h pc=%h cnt=%h, required 1 3024 3028 2",
                     bus.if_id_valid, bus.if_id_pc, bus.imem_addr, bus.redirect_cnt);
        end
        $display("normal select: ifpc=%h pc=%h", bus.if_id_pc, bus.imem_addr);
    endtask

    task automatic test_fault();
        bus.id_s_npc     = 2'd2;
        bus.id_inst_type = 2'd2;
        bus.id_jr_target = 32'h3022;
        step();
        clear_id();
        n_checks++;
        if (bus.fault !== 1'b1 || bus.if_id_valid !== 1'b0 || bus.imem_addr !== 32'h3028 ||
            bus.redirect_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL jr_misaligned: fault=%b valid=%b pc=%h cnt=%h, required 1 0 3028 2",
                     bus.fault, bus.if_id_valid, bus.imem_addr, bus.redirect_cnt);
        end
        $display("jr fault: fault=%b pc=%h", bus.fault, bus.imem_addr);
        for (int i = 0; i < 4; i++) begin
            bus.stall = (i % 2 == 1);
            step();
            n_checks++;
            if (bus.fault !== 1'b1 || bus.if_id_valid !== 1'b0 || bus.imem_addr !== 32'h3028 ||
                bus.if_id_inst !== 32'h0) begin
                n_fail++;
                $display("FAIL fault_frozen: fault=%b valid=%b pc=%h inst=%h, required 1 0 3028 0",
                         bus.fault, bus.if_id_valid, bus.imem_addr, bus.if_id_inst);
            end
            $display("fault hold %0d: pc=%h", i, bus.imem_addr);
        end
        bus.stall = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (bus.fault !== 1'b0 || bus.imem_addr !== 32'h3000 || bus.redirect_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL fault_reset: fault=%b pc=%h cnt=%h, required 0 3000 0",
                     bus.fault, bus.imem_addr, bus.redirect_cnt);
        end
        $display("fault reset: fault=%b pc=%h", bus.fault, bus.imem_addr);
    endtask

    task automatic test_cnt_wrap();
        step(); // boot
        bus.id_s_npc      = 2'd3;
        bus.id_inst_type  = 2'd3;
        bus.id_beq_target = 32'h3000;
        for (int i = 0; i < 65535; i++) begin
            step(); // capture
            step(); // redirect
        end
        n_checks++;
        if (bus.redirect_cnt !== 16'hFFFF || bus.imem_addr !== 32'h3000) begin
            n_fail++;
            $display("FAIL cnt_preload: cnt=%h pc=%h, required ffff 3000", bus.redirect_cnt, bus.imem_addr);
        end
        $display("cnt preload: cnt=%h", bus.redirect_cnt);
        step();
        step();
        clear_id();
        n_checks++;
        if (bus.redirect_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL cnt_wrap: cnt=%h, required 0000", bus.redirect_cnt);
        end
        $display("cnt wrap: cnt=%h", bus.redirect_cnt);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.stall = 1'b0;
        clear_id();
        test_reset();
        test_sequential();
        test_jump();
        test_beq_stall();
        test_normal_select();
        test_fault();
        test_cnt_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
